// File: rtl/square_drawer.sv
// Square rasteriser: queues {x, y, colour} requests in a small FIFO and emits
// one VGA pixel per cycle for each SQUARE_SIZE x SQUARE_SIZE square, clipping off-screen pixels.
module square_drawer #(
  parameter int unsigned SQUARE_SIZE = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       square_done
);

  localparam int unsigned D_W   = (SQUARE_SIZE > 1) ? $clog2(SQUARE_SIZE) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [D_W-1:0]   D_LAST   = D_W'(SQUARE_SIZE - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } req_t;

  req_t             fifo_mem [FIFO_DEPTH];
  req_t             in_req;
  req_t             pend_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       state_q, state_d;
  logic [7:0]       base_x_q;
  logic [6:0]       base_y_q;
  logic [2:0]       colour_q;
  logic [D_W-1:0]   dx_q, dy_q;
  logic             push, pop, last_pix, drawing, in_view;
  logic [8:0]       x_sum;
  logic [7:0]       y_sum;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_req   = '{x: in_x, y: in_y, colour: in_colour};
  assign in_ready = (count_q < CNT_FULL);
  assign push     = in_valid && in_ready && !reset;
  assign drawing  = (state_q == DRAW);
  assign last_pix = drawing && (dx_q == D_LAST) && (dy_q == D_LAST);

  // Next-state logic; pops happen on the IDLE->LOAD and DRAW->LOAD transitions
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = DRAW;
      DRAW: begin
        if (last_pix) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= in_req;
  end

  // Popped entry is parked in pend_q so the square on screen keeps its base until LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        pend_q   <= fifo_mem[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_x_q <= '0;
      base_y_q <= '0;
      colour_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
    end else if (state_q == LOAD) begin
      base_x_q <= pend_q.x;
      base_y_q <= pend_q.y;
      colour_q <= pend_q.colour;
      dx_q     <= '0;
      dy_q     <= '0;
    end else if (drawing) begin
      if (last_pix) begin
        dx_q <= '0;
        dy_q <= '0;
      end else if (dx_q == D_LAST) begin
        dx_q <= '0;
        dy_q <= dy_q + D_W'(1);
      end else begin
        dx_q <= dx_q + D_W'(1);
      end
    end
  end

  // Widened sums so a square hanging off the right/bottom edge clips instead of wrapping
  assign x_sum   = {1'b0, base_x_q} + 9'(dx_q);
  assign y_sum   = {1'b0, base_y_q} + 8'(dy_q);
  assign in_view = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));

  assign vga_x       = drawing ? x_sum[7:0] : '0;
  assign vga_y       = drawing ? y_sum[6:0] : '0;
  assign vga_colour  = drawing ? colour_q   : '0;
  assign vga_plot    = drawing && in_view;
  assign square_done = last_pix;
  assign busy        = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_square_drawer.sv
// Scoreboard bench for square_drawer: stimulus enqueues expected pixels,
// a negedge monitor pops and compares whenever a pixel is plotted or a square completes.
module tb_square_drawer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       square_done;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    logic       d;
  } pix_t;

  pix_t exp_q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   plot_cnt = 0;
  int   done_cnt = 0;

  square_drawer dut (
    .clk        (clk),
    .reset      (reset),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .square_done(square_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference raster: x fastest, clipped pixels are only visible on the done cycle
  task automatic model_square(input int x, input int y, input int c);
    pix_t e;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        int xs = x + dx;
        int ys = y + dy;
        e.x = 8'(xs);
        e.y = 7'(ys);
        e.c = 3'(c);
        e.p = (xs < 160) && (ys < 120);
        e.d = (dx == 3) && (dy == 3);
        if (e.p || e.d) exp_q.push_back(e);
      end
    end
  endtask

  task automatic push(input int x, input int y, input int c);
    int n = 0;
    @(negedge clk);
    in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c); in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_square(x, y, c);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (vga_plot || square_done) begin
      if (vga_plot) plot_cnt++;
      if (square_done) done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pix_x", vga_x, e.x);
        check("pix_y", vga_y, e.y);
        check("pix_colour", vga_colour, e.c);
        check("pix_plot", vga_plot, e.p);
        check("pix_done", square_done, e.d);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] rdy_exp;
    logic       rdy;
    int         acc;

    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_plot", vga_plot, 0);
    check("rst_done", square_done, 0);
    check("rst_busy", busy, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);

    // Single square with latency check
    plot_cnt = 0; done_cnt = 0;
    push(1, 53, 4);
    check("lat_e0_plot", vga_plot, 0);
    @(posedge clk); #1;
    check("lat_load_plot", vga_plot, 0);
    check("lat_load_busy", busy, 1);
    @(posedge clk); #1;
    check("lat_first_plot", vga_plot, 1);
    check("lat_first_x", vga_x, 1);
    check("lat_first_y", vga_y, 53);
    wait_idle();
    check("single_plots", plot_cnt, 16);
    check("single_done", done_cnt, 1);

    // Clipping at the bottom-right corner and fully off-screen
    plot_cnt = 0; done_cnt = 0;
    push(158, 118, 7);
    wait_idle();
    check("clip_corner_plots", plot_cnt, 4);
    check("clip_corner_done", done_cnt, 1);
    plot_cnt = 0; done_cnt = 0;
    push(255, 0, 2);
    wait_idle();
    check("clip_off_plots", plot_cnt, 0);
    check("clip_off_done", done_cnt, 1);

    // Back-pressure: six consecutive requests, the sixth meets a full FIFO
    plot_cnt = 0; done_cnt = 0; acc = 0;
    rdy_exp = 6'b011111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_x = 8'(20 * i + 5); in_y = 7'(10 * i); in_colour = 3'(i + 1); in_valid = 1'b1;
      rdy = in_ready;
      check("bp_ready", int'(rdy), int'(rdy_exp[i]));
      @(posedge clk);
      if (rdy) begin
        model_square(20 * i + 5, 10 * i, i + 1);
        acc++;
      end
    end
    #1 in_valid = 1'b0;
    check("bp_accepted", acc, 5);
    wait_idle();
    check("bp_plots", plot_cnt, 80);
    check("bp_done", done_cnt, 5);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset on the 7th pixel with two requests queued; in_valid is ignored under reset
    push(30, 30, 5);
    push(40, 40, 6);
    push(50, 50, 1);
    repeat (6) @(posedge clk);
    #1;
    check("mid_7th_x", vga_x, 32);
    check("mid_7th_y", vga_y, 31);
    reset = 1'b1;
    in_x = 8'd99; in_y = 7'd99; in_colour = 3'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("mid_plot", vga_plot, 0);
    check("mid_busy", busy, 0);
    check("mid_ready", in_ready, 1);
    plot_cnt = 0; done_cnt = 0;
    repeat (20) @(negedge clk);
    check("mid_no_plots", plot_cnt, 0);
    check("mid_no_done", done_cnt, 0);
    check("mid_still_idle", busy, 0);

    // Erase is an ordinary plot with colour 0
    plot_cnt = 0; done_cnt = 0;
    push(10, 20, 0);
    wait_idle();
    check("erase_plots", plot_cnt, 16);
    check("erase_done", done_cnt, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
